fp_unpack_pipe: RTL and testbench
=================================

// Module: fp_unpack_pipe
// PURPOSE
//  Two-stage pipelined IEEE-754 operand unpacker. It sits at the front of the FPU,
//  ahead of the mask/half-decoder logic. It splits a packed operand into sign,
//  unbiased exponent and normalized significand, and classifies the operand.
//  Denormals are normalized with a leading-zero count. Valid/ready handshake on both sides.
// PARAMETERS
//  EXP_W   8   exponent field width; bias = 2**(EXP_W-1)-1
//  FRAC_W  23  fraction field width; LZ_W = $clog2(FRAC_W+1)
// PORTS
//  clk        in   1                 clock, rising edge
//  rst_n      in   1                 reset, asynchronous assert, active-low
//  in_valid   in   1                 in_data valid
//  in_ready   out  1                 unpacker accepts in_data this cycle
//  in_data    in   1+EXP_W+FRAC_W    packed operand {sign, exp, frac}
//  out_valid  out  1                 outputs valid
//  out_ready  in   1                 consumer accepts outputs this cycle
//  out_sign   out  1                 sign bit
//  out_exp    out  EXP_W+1           unbiased exponent, two's complement
//  out_sig    out  FRAC_W+1          significand 1.f, MSB = hidden/leading one
//  out_lz     out  LZ_W              normalization shift applied (0 unless denormal)
//  out_zero, out_inf, out_nan, out_snan, out_denorm  out 1 each  class flags
// BEHAVIOUR
//  - Reset: every valid bit, output and flag is 0. in_ready is 1 once rst_n=1.
//  - Transfer: a beat moves when valid&&ready is high at a clock edge.
//    out_valid/out_* hold stable while out_valid && !out_ready.
//  - Stage S1 (registered): split the fields, classify, and count LZ over {1'b0,frac}.
//  - Stage S2 (registered): apply the shift and compute the exponent.
//  - Latency: exactly 2 cycles from accept to out_valid when out_ready=1.
//    Throughput is 1 beat/cycle.
//  - Stall: S2 loads iff !s2_valid || out_ready. S1 loads iff !s1_valid || S2 loads.
//    in_ready = !s1_valid || S2 loads. No bubbles, no drops, no duplicates.
//  - Simultaneous accept and emit on a full pipe: both occur in the same cycle.
//  - Normal (0<E<max): exp = E - bias, sig = {1,frac}, lz = 0.
//  - Denormal (E=0, frac!=0):
//    - lz = leading zeros of {1'b0,frac}, range 1..FRAC_W.
//    - sig = {1'b0,frac} << lz.
//    - exp = 1 - bias - lz.
//    - denorm = 1.
//  - Zero (E=0, frac=0): zero = 1, exp = 0, sig = 0, lz = 0. The sign is preserved.
//  - Inf (E=all ones, frac=0): inf = 1, exp = 0, sig = {1,frac}.
//  - NaN (E=all ones, frac!=0): nan = 1, snan = ~frac[FRAC_W-1], sig = {1,frac}
//    (payload kept), exp = 0.
//  - Exactly one of {zero, inf, nan, denorm, normal} holds per beat.
//    snan is set only with nan.
//  - Reset mid-operation: in-flight beats are discarded. The outputs return to
//    reset values asynchronously.
// TESTING (EXP_W=8, FRAC_W=23)
//  - 0x3F800000, out_ready=1 -> 2 cycles later:
//    sign 0, exp 9'h000, sig 24'h800000, lz 0, all flags 0.
//  - 0x00000001 -> exp 9'h16B (-149), sig 24'h800000, lz 23, denorm 1.
//    Also 0x00400000 -> exp -127, lz 1.
//  - 0x80000000 -> sign 1, zero 1.
//    0x7F800000 -> inf 1.
//    0x7FC00000 -> nan 1, snan 0.
//    0x7F800001 -> nan 1, snan 1.
//  - Back-to-back stream of 8 operands, out_ready low for 3 cycles mid-stream ->
//    in_ready drops after 2 held beats, outputs stay stable, all 8 emerge in order.
//  - rst_n pulsed low with 2 beats in flight -> out_valid=0 immediately.
//    First post-reset beat emerges with 2-cycle latency.
//  - Random operands vs reference model, random out_ready ->
//    fields, flags and ordering match exactly.

Source files
------------

// File: rtl/fp_unpack_pipe.sv
// ============================================================================
// Module      : fp_unpack_pipe
// Description : Two-stage pipelined IEEE-754 operand unpacker with valid/ready
//               handshake; splits, classifies and normalizes one operand/cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_unpack_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  localparam int LZ_W  = $clog2(FRAC_W + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [EXP_W+FRAC_W:0]     in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_sign,
  output logic [EXP_W:0]            out_exp,
  output logic [FRAC_W:0]           out_sig,
  output logic [LZ_W-1:0]           out_lz,
  output logic                      out_zero,
  output logic                      out_inf,
  output logic                      out_nan,
  output logic                      out_snan,
  output logic                      out_denorm
);

  localparam logic [EXP_W:0] c_bias = (EXP_W + 1)'((2 ** (EXP_W - 1)) - 1);
  localparam logic [EXP_W:0] c_one  = (EXP_W + 1)'(1);

  // Stage-load enables
  logic w_s1_load;
  logic w_s2_load;

  // Input field split and classification
  logic              w_sign;
  logic [EXP_W-1:0]  w_exp_f;
  logic [FRAC_W-1:0] w_frac;
  logic              w_exp_zero;
  logic              w_exp_max;
  logic              w_frac_nz;
  logic [LZ_W-1:0]   w_lz;

  // Stage 1 registers
  logic              r_s1_valid;
  logic              r_s1_sign;
  logic [EXP_W-1:0]  r_s1_exp;
  logic [FRAC_W-1:0] r_s1_frac;
  logic [LZ_W-1:0]   r_s1_lz;
  logic              r_s1_zero;
  logic              r_s1_inf;
  logic              r_s1_nan;
  logic              r_s1_snan;
  logic              r_s1_denorm;

  // Stage 2 datapath
  logic [FRAC_W:0]   w_sig_denorm;
  logic [FRAC_W:0]   w_s2_sig;
  logic [EXP_W:0]    w_s2_exp;

  // Stage 2 registers (drive the outputs)
  logic              r_s2_valid;
  logic              r_sign;
  logic [EXP_W:0]    r_exp;
  logic [FRAC_W:0]   r_sig;
  logic [LZ_W-1:0]   r_lz;
  logic              r_zero;
  logic              r_inf;
  logic              r_nan;
  logic              r_snan;
  logic              r_denorm;

  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign in_ready  = w_s1_load;

  assign w_sign     = in_data[EXP_W+FRAC_W];
  assign w_exp_f    = in_data[FRAC_W +: EXP_W];
  assign w_frac     = in_data[FRAC_W-1:0];
  assign w_exp_zero = ~|w_exp_f;
  assign w_exp_max  = &w_exp_f;
  assign w_frac_nz  = |w_frac;

  // Highest set fraction bit wins; the extra 1 accounts for the hidden-bit slot.
  always_comb begin
    w_lz = '0;
    for (int i = 0; i < FRAC_W; i++) begin
      if (w_frac[i]) begin
        w_lz = LZ_W'(FRAC_W - i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_exp    <= '0;
      r_s1_frac   <= '0;
      r_s1_lz     <= '0;
      r_s1_zero   <= 1'b0;
      r_s1_inf    <= 1'b0;
      r_s1_nan    <= 1'b0;
      r_s1_snan   <= 1'b0;
      r_s1_denorm <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_valid  <= in_valid;
      r_s1_sign   <= w_sign;
      r_s1_exp    <= w_exp_f;
      r_s1_frac   <= w_frac;
      r_s1_lz     <= (w_exp_zero && w_frac_nz) ? w_lz : '0;
      r_s1_zero   <= w_exp_zero && !w_frac_nz;
      r_s1_inf    <= w_exp_max && !w_frac_nz;
      r_s1_nan    <= w_exp_max && w_frac_nz;
      r_s1_snan   <= w_exp_max && w_frac_nz && !w_frac[FRAC_W-1];
      r_s1_denorm <= w_exp_zero && w_frac_nz;
    end
  end

  assign w_sig_denorm = {1'b0, r_s1_frac} << r_s1_lz;

  always_comb begin
    w_s2_sig = {1'b1, r_s1_frac};
    w_s2_exp = {1'b0, r_s1_exp} - c_bias;
    if (r_s1_zero) begin
      w_s2_sig = '0;
      w_s2_exp = '0;
    end else if (r_s1_denorm) begin
      w_s2_sig = w_sig_denorm;
      w_s2_exp = c_one - c_bias - (EXP_W + 1)'(r_s1_lz);
    end else if (r_s1_inf || r_s1_nan) begin
      w_s2_exp = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_sign     <= 1'b0;
      r_exp      <= '0;
      r_sig      <= '0;
      r_lz       <= '0;
      r_zero     <= 1'b0;
      r_inf      <= 1'b0;
      r_nan      <= 1'b0;
      r_snan     <= 1'b0;
      r_denorm   <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      r_sign     <= r_s1_sign;
      r_exp      <= w_s2_exp;
      r_sig      <= w_s2_sig;
      r_lz       <= r_s1_lz;
      r_zero     <= r_s1_zero;
      r_inf      <= r_s1_inf;
      r_nan      <= r_s1_nan;
      r_snan     <= r_s1_snan;
      r_denorm   <= r_s1_denorm;
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_sign   = r_sign;
  assign out_exp    = r_exp;
  assign out_sig    = r_sig;
  assign out_lz     = r_lz;
  assign out_zero   = r_zero;
  assign out_inf    = r_inf;
  assign out_nan    = r_nan;
  assign out_snan   = r_snan;
  assign out_denorm = r_denorm;

endmodule

`default_nettype wire

// File: tb/tb_fp_unpack_pipe.sv
// ============================================================================
// Module      : tb_fp_unpack_pipe
// Description : Directed and randomized checks of fp_unpack_pipe (binary32).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_unpack_pipe;

  typedef struct packed {
    logic        sign;
    logic [8:0]  exp;
    logic [23:0] sig;
    logic [4:0]  lz;
    logic        zero;
    logic        inf;
    logic        nan;
    logic        snan;
    logic        denorm;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [8:0]  out_exp;
  logic [23:0] out_sig;
  logic [4:0]  out_lz;
  logic        out_zero, out_inf, out_nan, out_snan, out_denorm;
  obs_t        obs;

  int   total = 0;
  int   bad   = 0;
  obs_t q[$];
  logic hold  = 1'b0;
  obs_t held;

  logic [31:0] ops[8] = '{32'h3F800000, 32'h00000001, 32'hC0490FDB, 32'h7F800001,
                          32'h80000000, 32'h00400000, 32'h7F7FFFFF, 32'h7FC00000};

  fp_unpack_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_sig(out_sig), .out_lz(out_lz),
    .out_zero(out_zero), .out_inf(out_inf), .out_nan(out_nan),
    .out_snan(out_snan), .out_denorm(out_denorm)
  );

  always #5 clk = ~clk;

  assign obs = {out_sign, out_exp, out_sig, out_lz, out_zero, out_inf, out_nan, out_snan, out_denorm};

  // Reference: value-level decode of a binary32 word using integer arithmetic.
  function automatic obs_t model(input logic [31:0] d);
    obs_t m;
    int e  = int'(d[30:23]);
    int f  = int'(d[22:0]);
    int s;
    int lz = 0;
    m = '0;
    m.sign = d[31];
    if (e == 255) begin
      m.sig = 24'(32'h800000 + f);
      if (f == 0) m.inf = 1'b1;
      else begin
        m.nan  = 1'b1;
        m.snan = (f < 32'h400000);
      end
    end else if (e == 0) begin
      if (f == 0) m.zero = 1'b1;
      else begin
        s = f;
        while (s < 32'h800000) begin
          s  = s * 2;
          lz = lz + 1;
        end
        m.sig    = 24'(s);
        m.lz     = 5'(lz);
        m.exp    = 9'(1 - 127 - lz);
        m.denorm = 1'b1;
      end
    end else begin
      m.exp = 9'(e - 127);
      m.sig = 24'(32'h800000 + f);
    end
    return m;
  endfunction

  function automatic obs_t mk(input logic s, input logic [8:0] e, input logic [23:0] g,
                              input logic [4:0] l, input logic [4:0] fl);
    return {s, e, g, l, fl};
  endfunction

  task automatic chk_obs(input string tag, input obs_t got, input obs_t exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // One clock: inputs already driven just after the falling edge.
  task automatic cycle(output logic acc, output logic ov, output obs_t o);
    obs_t e;
    #1;
    acc = in_valid && in_ready;
    ov  = out_valid;
    o   = obs;
    if (hold) begin
      chk_bit("hold_valid", out_valid, 1'b1);
      chk_obs("hold_data", obs, held);
    end
    if (out_valid && out_ready) begin
      total++;
      assert (q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_beat: observed=%h expected=none", obs);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk_obs("stream", obs, e);
      end
    end
    hold = out_valid && !out_ready;
    held = obs;
    if (acc) q.push_back(model(in_data));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_single(input logic [31:0] d, input obs_t exp, input string tag);
    logic acc, ov;
    obs_t o;
    in_valid = 1'b1; in_data = d; out_ready = 1'b1;
    cycle(acc, ov, o);
    chk_bit({tag, "_accept"}, acc, 1'b1);
    in_valid = 1'b0;
    cycle(acc, ov, o);
    chk_bit({tag, "_lat1"}, ov, 1'b0);
    cycle(acc, ov, o);
    chk_bit({tag, "_lat2"}, ov, 1'b1);
    chk_obs(tag, o, exp);
  endtask

  task automatic drain(input string tag);
    logic acc, ov;
    obs_t o;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && (q.size() != 0 || out_valid); i++) cycle(acc, ov, o);
    total++;
    assert (q.size() == 0 && !out_valid) else begin
      bad++;
      $error("FAIL %s_drain: observed=%0d left expected=0", tag, q.size());
    end
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 7))
      0: r = {r[31], 8'h00, 23'(r[22:0] >> $urandom_range(0, 22))};
      1: r = {r[31], 31'h0};
      2: r = {r[31], 8'hFF, ($urandom_range(0, 1) == 0) ? 23'h0 : r[22:0]};
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    logic acc, ov;
    obs_t o;
    int   idx, k;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_bit("reset_out_valid", out_valid, 1'b0);
    chk_obs("reset_outputs", obs, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_bit("reset_in_ready", in_ready, 1'b1);

    // Directed operands with hand-derived expectations (flags: zero,inf,nan,snan,denorm)
    check_single(32'h3F800000, mk(1'b0, 9'h000, 24'h800000, 5'd0,  5'b00000), "one");
    check_single(32'h00000001, mk(1'b0, 9'h16B, 24'h800000, 5'd23, 5'b00001), "min_denorm");
    check_single(32'h00400000, mk(1'b0, 9'h181, 24'h800000, 5'd1,  5'b00001), "max_lz1_denorm");
    check_single(32'h80000000, mk(1'b1, 9'h000, 24'h000000, 5'd0,  5'b10000), "neg_zero");
    check_single(32'h7F800000, mk(1'b0, 9'h000, 24'h800000, 5'd0,  5'b01000), "inf");
    check_single(32'h7FC00000, mk(1'b0, 9'h000, 24'hC00000, 5'd0,  5'b00100), "qnan");
    check_single(32'h7F800001, mk(1'b0, 9'h000, 24'h800001, 5'd0,  5'b00110), "snan");
    check_single(32'hC0490FDB, mk(1'b1, 9'h001, 24'hC90FDB, 5'd0,  5'b00000), "neg_pi");
    check_single(32'h7F7FFFFF, mk(1'b0, 9'h07F, 24'hFFFFFF, 5'd0,  5'b00000), "max_normal");
    check_single(32'h00800000, mk(1'b0, 9'h182, 24'h800000, 5'd0,  5'b00000), "min_normal");

    // Back-to-back stream with a 3-cycle consumer stall on a full pipe
    idx = 0; k = 0;
    while (idx < 8 && k < 40) begin
      in_valid = 1'b1; in_data = ops[idx];
      out_ready = !(k >= 4 && k < 7);
      cycle(acc, ov, o);
      if (k >= 4 && k < 7) chk_bit("stall_in_ready", acc, 1'b0);
      if (acc) idx++;
      k++;
    end
    chk_bit("stream_all_sent", idx == 8, 1'b1);
    drain("stream");

    // Asynchronous reset with two beats in flight
    in_valid = 1'b1; in_data = 32'h40000000; out_ready = 1'b0;
    cycle(acc, ov, o);
    in_data = 32'h40400000;
    cycle(acc, ov, o);
    chk_bit("inflight_out_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_bit("async_reset_valid", out_valid, 1'b0);
    chk_obs("async_reset_outputs", obs, '0);
    q.delete();
    hold = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_single(32'h40400000, mk(1'b0, 9'h001, 24'hC00000, 5'd0, 5'b00000), "post_reset");

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = rand_op();
      out_ready = ($urandom_range(0, 2) != 0);
      cycle(acc, ov, o);
    end
    drain("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
